digit_argmax: RTL and testbench

Classification stage directly downstream of the neural-network controller and its output-layer register. It captures the 10 output-neuron values when the output layer is written and scans them sequentially, one neuron per cycle, to find the winning digit. It holds the result under a valid/acknowledge handshake until the consumer (display or host interface) takes it. Optionally it also reports the best-versus-runner-up margin as a confidence indicator.

---
 rtl/digit_argmax.sv | 189 ++++++++++++++++++
 tb/tb_digit_argmax.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_argmax.sv
// digit_argmax: captures the output-layer neurons and scans them one per cycle
// to find the winning digit. The result is held under a valid/ack handshake.
// Optional feature macro: ARGMAX_MARGIN_EN (builds best-vs-second margin and lowConf).
module digit_argmax #(
  parameter int WIDTH       = 8,
  parameter int NUM_CLASSES = 10,
  parameter int MARGIN_TH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CLASSES*WIDTH-1:0] neurons,
  input  logic                         capture,
  input  logic                         outAck,
  output logic                         outValid,
  output logic [3:0]                   digit,
  output logic [WIDTH-1:0]             maxValue,
  output logic [WIDTH-1:0]             margin,
  output logic                         lowConf,
  output logic                         busy,
  output logic                         overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   buf_q [NUM_CLASSES];
  logic [WIDTH-1:0]   buf_d [NUM_CLASSES];
  logic [WIDTH-1:0]   best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [3:0]         idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         digit_q, digit_d;
  logic [WIDTH-1:0]   max_value_q, max_value_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic               accept;
  logic [WIDTH-1:0]   v;
  logic [WIDTH-1:0]   best_n;
  logic [3:0]         best_idx_n;

`ifdef ARGMAX_MARGIN_EN
  logic [WIDTH-1:0]   second_q, second_d, second_n;
  logic [WIDTH-1:0]   margin_q, margin_d;
  logic               low_conf_q, low_conf_d;
`endif

  assign accept = capture && ((state_q == IDLE) || ((state_q == DONE) && outAck));
  assign v      = buf_q[idx_q];

  // Next-state, scan datapath and registered-output updates.
  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    digit_d     = digit_q;
    max_value_d = max_value_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    best_n      = best_q;
    best_idx_n  = best_idx_q;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) buf_d[i] = buf_q[i];
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    second_n    = second_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;
`endif

    // Strict compare: lowest index wins ties.
    if (v > best_q) begin
      best_n     = v;
      best_idx_n = idx_q;
`ifdef ARGMAX_MARGIN_EN
      second_n   = best_q;
`endif
    end
`ifdef ARGMAX_MARGIN_EN
    else if (v > second_q) begin
      second_n = v;
    end
`endif

    if (accept) begin
      for (int unsigned i = 0; i < NUM_CLASSES; i++) buf_d[i] = neurons[i*WIDTH +: WIDTH];
      best_d      = neurons[WIDTH-1:0];
      best_idx_d  = '0;
      idx_d       = 4'd1;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      busy_d      = 1'b1;
      state_d     = SCAN;
`ifdef ARGMAX_MARGIN_EN
      second_d    = '0;
`endif
    end else begin
      case (state_q)
        SCAN: begin
          if (capture) overrun_d = 1'b1;
          best_d     = best_n;
          best_idx_d = best_idx_n;
          idx_d      = idx_q + 4'd1;
`ifdef ARGMAX_MARGIN_EN
          second_d   = second_n;
`endif
          // The final compare folds straight into the result registers.
          if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            digit_d     = best_idx_n;
            max_value_d = best_n;
`ifdef ARGMAX_MARGIN_EN
            margin_d    = best_n - second_n;
            low_conf_d  = ((best_n - second_n) < WIDTH'(MARGIN_TH));
`endif
          end
        end
        DONE: begin
          if (outAck) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else if (capture) begin
            overrun_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and result registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      best_q      <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      digit_q     <= '0;
      max_value_q <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
      low_conf_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      digit_q     <= digit_d;
      max_value_q <= max_value_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
      low_conf_q  <= low_conf_d;
`endif
    end
  end

  // Neuron buffer; contents are irrelevant until a capture loads it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CLASSES; i++) buf_q[i] <= buf_d[i];
  end

  assign outValid = out_valid_q;
  assign digit    = digit_q;
  assign maxValue = max_value_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
`ifdef ARGMAX_MARGIN_EN
  assign margin   = margin_q;
  assign lowConf  = low_conf_q;
`else
  assign margin   = '0;
  assign lowConf  = 1'b0;
`endif

endmodule

// File: tb/tb_digit_argmax.sv
// Directed bench for digit_argmax with immediate-assertion checks.
module tb_digit_argmax;

  localparam int W = 8;
  localparam int N = 10;
`ifdef ARGMAX_MARGIN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] neurons;
  logic           capture;
  logic           outAck;
  logic           outValid;
  logic [3:0]     digit;
  logic [W-1:0]   maxValue;
  logic [W-1:0]   margin;
  logic           lowConf;
  logic           busy;
  logic           overrun;

  int checks   = 0;
  int failures = 0;

  digit_argmax #(.WIDTH(W), .NUM_CLASSES(N), .MARGIN_TH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .neurons  (neurons),
    .capture  (capture),
    .outAck   (outAck),
    .outValid (outValid),
    .digit    (digit),
    .maxValue (maxValue),
    .margin   (margin),
    .lowConf  (lowConf),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] vec(input int fill, input int i1, input int v1,
                                          input int i2, input int v2);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(fill);
    r[i1*W +: W] = W'(v1);
    r[i2*W +: W] = W'(v2);
    return r;
  endfunction

  initial begin
    logic [3:0]   hold_digit;
    logic [W-1:0] hold_max;
    rst     = 1'b0;
    neurons = '0;
    capture = 1'b0;
    outAck  = 1'b0;
    #2;
    check("reset_valid",   outValid, 0);
    check("reset_busy",    busy,     0);
    check("reset_digit",   digit,    0);
    check("reset_max",     maxValue, 0);
    check("reset_overrun", overrun,  0);
    #10 rst = 1'b1;
    tick();

    // Basic scan: 3 -> 200, 9 -> 10, rest 5.
    neurons = vec(5, 3, 200, 9, 10);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    neurons = vec(7, 0, 0, 1, 0);
    check("basic_busy", busy, 1);
    for (int i = 0; i < 8; i++) tick();
    check("basic_not_valid_yet", outValid, 0);
    tick();
    check("basic_valid_lat9", outValid, 1);
    check("basic_busy_off", busy, 0);
    check("basic_digit", digit, 3);
    check("basic_max", maxValue, 200);
    check("basic_margin", margin, MEN ? 190 : 0);
    check("basic_lowconf", lowConf, 0);

    // Handshake hold for 20 cycles.
    hold_digit = digit;
    hold_max   = maxValue;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", outValid, 1);
      check("hold_digit", digit, 3);
      check("hold_max", maxValue, 200);
    end

    // Ack together with capture: tie vector starts immediately.
    neurons = vec(0, 2, 150, 7, 150);
    outAck  = 1'b1;
    capture = 1'b1;
    tick();
    outAck  = 1'b0;
    capture = 1'b0;
    check("ackcap_valid_low", outValid, 0);
    check("ackcap_busy", busy, 1);
    for (int i = 0; i < 8; i++) tick();
    check("tie_not_valid_yet", outValid, 0);
    tick();
    check("tie_valid", outValid, 1);
    check("tie_digit", digit, 2);
    check("tie_max", maxValue, 150);
    check("tie_margin", margin, 0);
    check("tie_lowconf", lowConf, MEN ? 1 : 0);

    // Ack alone returns to idle.
    outAck = 1'b1;
    tick();
    outAck = 1'b0;
    check("ack_valid_low", outValid, 0);
    check("ack_idle_busy", busy, 0);
    tick();
    check("idle_stays_invalid", outValid, 0);

    // Overrun: capture at scan cycle 4 is dropped.
    neurons = vec(5, 3, 200, 9, 10);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    neurons = vec(1, 8, 250, 8, 250);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_busy", busy, 1);
    for (int i = 0; i < 4; i++) tick();
    check("ovr_not_valid_yet", outValid, 0);
    tick();
    check("ovr_valid", outValid, 1);
    check("ovr_digit_first_vec", digit, 3);
    check("ovr_max_first_vec", maxValue, 200);
    check("ovr_sticky", overrun, 1);

    // Capture in DONE without ack is dropped too.
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check("done_drop_valid", outValid, 1);
    check("done_drop_digit", digit, 3);

    // Accepted capture clears overrun; neurons change right after the edge.
    outAck  = 1'b1;
    capture = 1'b1;
    tick();
    outAck  = 1'b0;
    capture = 1'b0;
    neurons = vec(0, 4, 255, 5, 255);
    check("ovr_cleared", overrun, 0);
    for (int i = 0; i < 9; i++) tick();
    check("v2_valid", outValid, 1);
    check("v2_digit", digit, 8);
    check("v2_max", maxValue, 250);
    check("v2_margin", margin, MEN ? 249 : 0);

    // Mid-scan reset.
    outAck = 1'b1;
    tick();
    outAck  = 1'b0;
    neurons = vec(5, 3, 200, 9, 10);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b0;
    #1;
    check("mrst_valid", outValid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_digit", digit, 0);
    check("mrst_max", maxValue, 0);
    check("mrst_margin", margin, 0);
    check("mrst_lowconf", lowConf, 0);
    check("mrst_overrun", overrun, 0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);
    neurons = vec(0, 0, 255, 0, 255);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("fresh_not_valid_yet", outValid, 0);
    tick();
    check("fresh_valid", outValid, 1);
    check("fresh_digit", digit, 0);
    check("fresh_max", maxValue, 255);
    check("fresh_margin", margin, MEN ? 255 : 0);
    check("fresh_lowconf", lowConf, 0);

    if (hold_digit !== 4'd3 || hold_max !== 8'd200) begin
      checks++;
      failures++;
      $display("FAIL hold_snapshot observed=%0d/%0d expected=3/200", hold_digit, hold_max);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
